nv_nvdla_cacc_csb_slave: RTL and testbench
==========================================

NV_NVDLA_CACC_CSB_SLAVE -- requirements
Module: NV_NVDLA_CACC_csb_slave

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-low (nvdla_core_clk, nvdla_core_rstn).
REQ-002 nvdla_core_clk  in  1  core clock; every flop is rising-edge.
REQ-003 nvdla_core_rstn  in  1  asynchronous active-low reset.
REQ-004 csb2cacc_req_pvld  in  1  request valid, from the retimed CSB request pipe.
REQ-005 csb2cacc_req_prdy  out  1  request ready.
REQ-006 csb2cacc_req_pd  in  63  request packet: addr[21:0] (word address), wdat[53:22], write[54], nposted[55], srcpriv[56], wrbe[60:57], level[62:61].
REQ-007 cacc2csb_resp_valid  out  1  one-cycle response pulse, with no backpressure.
REQ-008 cacc2csb_resp_pd  out  34  response packet: [33] type (0=read, 1=write), [32] error, [31:0] rdata.
REQ-009 reg_offset  out  12  byte offset of the current group access.
REQ-010 reg_wr_data  out  32  write data.
REQ-011 d0_reg_wr_en / d1_reg_wr_en  out  1 each  write strobe for group 0 / group 1.
REQ-012 d0_reg_rd_data / d1_reg_rd_data  in  32 each  combinational read data from group 0 / group 1.
REQ-013 reg2dp_op_en  out  1  op_en of the consumer group.
REQ-014 dp2reg_done  in  1  single-cycle pulse marking the end of the consumer group's layer.

Function
REQ-015 csb2cacc_req_prdy SHALL be constant 1'b1, including during reset; the upstream pipe ignores ready.
REQ-016 Accept is pvld=1 in cycle N; the request is captured into stage-1 flops at the end of cycle N.
REQ-017 Decode and register access SHALL occur in cycle N+1, and register writes take effect at the end of cycle N+1.
REQ-018 The response SHALL be registered, so resp_valid is high in cycle N+2.
REQ-019 The block SHALL be fully pipelined and accept one request per cycle with no bubbles.
REQ-020 A read accepted in cycle N+1 SHALL observe a write accepted in cycle N.
REQ-021 Byte address = {addr,2'b00}; the request is in-window when addr[21:10]==12'h009 (byte window 0x9000-0x9FFF), and offset = byte address[11:0].
REQ-022 Single registers (not grouped), decoded internally:
- 0x000 S_STATUS (RO): [1:0] group-0 status, [17:16] group-1 status; status is 0 idle (op_en=0), 1 running (op_en=1 and group==consumer), 2 pending (op_en=1 and group!=consumer).
- 0x004 S_POINTER: [0] producer (RW), [16] consumer (RO).
REQ-023 Group register 0x008 D_OP_ENABLE [0] SHALL be stored internally per group; all other group offsets are forwarded to the external group register file.
REQ-024 Group writes SHALL go to the group selected by the producer bit: d0_reg_wr_en when producer=0, d1_reg_wr_en when producer=1.
REQ-025 Group reads SHALL be muxed by the producer bit.
REQ-026 Forwarded group write enables SHALL be asserted only for in-window writes at offsets >=0x00C.
REQ-027 wrbe SHALL be ignored: all writes are full 32-bit writes.
REQ-028 Writes to RO fields SHALL be ignored, with no error.
REQ-029 Response generation:
- reads always respond with type 0 and rdata;
- writes respond only when nposted=1, with type 1 and rdata 0;
- posted writes produce no response.
REQ-030 Out-of-window requests SHALL have no register side effect; a read or non-posted write SHALL respond with error=1 and rdata 0.
REQ-031 In-window unmapped offsets below 0x00C (0x00C itself is forwarded) SHALL read 0 with error=0.
REQ-032 Outputs reg_offset and reg_wr_data SHALL be driven from stage-1 flops.
REQ-033 On dp2reg_done, the consumer bit SHALL toggle and the op_en of the pre-toggle consumer group SHALL clear, both at the same edge.
REQ-034 reg2dp_op_en SHALL equal the op_en of the current consumer group.
REQ-035 When a write of op_en=1 to group G coincides with a done that clears G, the write SHALL win and G's op_en ends at 1.
REQ-036 Consumer toggling SHALL wrap 1->0.

Reset
REQ-037 During reset, resp_valid=0, resp_pd=0, stage-1 valid=0, all wr_en=0, reg_offset=0, reg_wr_data=0, producer=0, consumer=0, both op_en=0, reg2dp_op_en=0.
REQ-038 Reset asserted mid-operation SHALL drop any in-flight request with no response; the first post-reset accept responds 2 cycles later.
REQ-039 Stage-1 datapath flops need not be reset, but their outputs SHALL be gated by the reset stage-1 valid.

Verification
REQ-040 Read of 0x9004 (addr=0x2401) right after reset -> resp_valid in cycle N+2, resp_pd={0,0,32'h0}.
REQ-041 Non-posted write of 1 to S_POINTER, then in the next cycle a non-posted write of 0xABCD to 0x9010 -> d1_reg_wr_en pulses with reg_offset=0x010 and reg_wr_data=0xABCD; both responses have type=1, error=0.
REQ-042 With producer=0, write op_en=1 to group 0, then read 0x9000 -> rdata=0x00000001 and reg2dp_op_en=1. Pulse dp2reg_done, then read 0x9004 -> consumer bit16=1, op_en0=0, reg2dp_op_en=0.
REQ-043 Posted write, then a read to addr 0x0000 (out-of-window), in back-to-back cycles -> exactly one response, with type 0, error=1, rdata 0, and no wr_en pulse.
REQ-044 Write op_en=1 to group 0 while consumer=0, in the same cycle as a dp2reg_done pulse -> op_en0 ends at 1, and consumer=1.
REQ-045 Assert reset in the cycle after an accept -> no resp_valid is issued, and all outputs return to their reset values.

Source files
------------

// File: rtl/nv_nvdla_cacc_csb_slave.sv
// CACC CSB slave: two-stage request pipe, ping-pong register group select and
// op_en/consumer tracking for the accumulator's double-buffered register file.
module nv_nvdla_cacc_csb_slave (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        csb2cacc_req_pvld,
    output logic        csb2cacc_req_prdy,
    input  logic [62:0] csb2cacc_req_pd,
    output logic        cacc2csb_resp_valid,
    output logic [33:0] cacc2csb_resp_pd,
    output logic [11:0] reg_offset,
    output logic [31:0] reg_wr_data,
    output logic        d0_reg_wr_en,
    output logic        d1_reg_wr_en,
    input  logic [31:0] d0_reg_rd_data,
    input  logic [31:0] d1_reg_rd_data,
    output logic        reg2dp_op_en,
    input  logic        dp2reg_done
);

    logic        s1_valid;
    logic [21:0] s1_addr;
    logic [31:0] s1_wdat;
    logic        s1_write;
    logic        s1_nposted;

    logic        producer;
    logic        consumer;
    logic [1:0]  op_en;

    logic        in_win;
    logic [11:0] offset;
    logic        wr_int;
    logic        grp_fwd;
    logic [1:0]  status0;
    logic [1:0]  status1;
    logic [31:0] rd_data;
    logic        unused_req;

    // srcpriv, wrbe and level carry no meaning here: every write is full-word
    assign unused_req = ^csb2cacc_req_pd[62:56];

    assign csb2cacc_req_prdy = 1'b1;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= csb2cacc_req_pvld;
        end
    end

    // Datapath capture is left unreset; everything downstream is qualified by s1_valid
    always_ff @(posedge nvdla_core_clk) begin
        if (csb2cacc_req_pvld) begin
            s1_addr    <= csb2cacc_req_pd[21:0];
            s1_wdat    <= csb2cacc_req_pd[53:22];
            s1_write   <= csb2cacc_req_pd[54];
            s1_nposted <= csb2cacc_req_pd[55];
        end
    end

    assign in_win  = s1_valid && (s1_addr[21:10] == 12'h009);
    assign offset  = {s1_addr[9:0], 2'b00};
    assign wr_int  = in_win && s1_write;
    assign grp_fwd = wr_int && (offset >= 12'h00C);

    assign reg_offset   = s1_valid ? offset : 12'h000;
    assign reg_wr_data  = s1_valid ? s1_wdat : 32'h0;
    assign d0_reg_wr_en = grp_fwd && !producer;
    assign d1_reg_wr_en = grp_fwd && producer;

    assign status0 = !op_en[0] ? 2'd0 : (consumer == 1'b0) ? 2'd1 : 2'd2;
    assign status1 = !op_en[1] ? 2'd0 : (consumer == 1'b1) ? 2'd1 : 2'd2;

    always_comb begin
        rd_data = 32'h0;
        if (offset >= 12'h00C) begin
            rd_data = producer ? d1_reg_rd_data : d0_reg_rd_data;
        end else begin
            case (offset)
                12'h000: rd_data = {14'h0, status1, 14'h0, status0};
                12'h004: rd_data = {15'h0, consumer, 15'h0, producer};
                12'h008: rd_data = {31'h0, op_en[producer]};
                default: rd_data = 32'h0;
            endcase
        end
    end

    // A same-edge op_en write overrides the clear from dp2reg_done
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            producer <= 1'b0;
            consumer <= 1'b0;
            op_en    <= 2'b00;
        end else begin
            if (dp2reg_done) begin
                consumer        <= ~consumer;
                op_en[consumer] <= 1'b0;
            end
            if (wr_int && offset == 12'h004) begin
                producer <= s1_wdat[0];
            end
            if (wr_int && offset == 12'h008) begin
                op_en[producer] <= s1_wdat[0];
            end
        end
    end

    assign reg2dp_op_en = op_en[consumer];

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cacc2csb_resp_valid <= 1'b0;
            cacc2csb_resp_pd    <= 34'h0;
        end else begin
            cacc2csb_resp_valid <= s1_valid && (!s1_write || s1_nposted);
            if (s1_valid && (!s1_write || s1_nposted)) begin
                cacc2csb_resp_pd <= {s1_write, !in_win,
                                     (in_win && !s1_write) ? rd_data : 32'h0};
            end else begin
                cacc2csb_resp_pd <= 34'h0;
            end
        end
    end

endmodule

// File: tb/tb_nv_nvdla_cacc_csb_slave.sv
// Directed bench for the CACC CSB slave: pipeline timing, group routing,
// op_en/consumer handshake, window errors and mid-operation reset.
module tb_nv_nvdla_cacc_csb_slave;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pvld;
    logic        prdy;
    logic [62:0] pd;
    logic        resp_valid;
    logic [33:0] resp_pd;
    logic [11:0] reg_offset;
    logic [31:0] reg_wr_data;
    logic        d0_wr_en;
    logic        d1_wr_en;
    logic [31:0] d0_rd;
    logic [31:0] d1_rd;
    logic        op_en_out;
    logic        done;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int resp_cnt;
    logic [33:0] pd_cap;

    always #5 clk = ~clk;

    nv_nvdla_cacc_csb_slave dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rstn     (rstn),
        .csb2cacc_req_pvld   (pvld),
        .csb2cacc_req_prdy   (prdy),
        .csb2cacc_req_pd     (pd),
        .cacc2csb_resp_valid (resp_valid),
        .cacc2csb_resp_pd    (resp_pd),
        .reg_offset          (reg_offset),
        .reg_wr_data         (reg_wr_data),
        .d0_reg_wr_en        (d0_wr_en),
        .d1_reg_wr_en        (d1_wr_en),
        .d0_reg_rd_data      (d0_rd),
        .d1_reg_rd_data      (d1_rd),
        .reg2dp_op_en        (op_en_out),
        .dp2reg_done         (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [21:0] a, input logic [31:0] d,
                         input logic w, input logic np);
        pvld = 1'b1;
        pd   = {2'b00, 4'h1, 1'b0, np, w, d, a};
    endtask

    task automatic idle;
        pvld = 1'b0;
        pd   = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp)
        else begin
            miss_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0; pvld = 1'b0; pd = '0; done = 1'b0;
        d0_rd = 32'h1111_1111; d1_rd = 32'h2222_2222;
        tick; tick;
        chk("rst_prdy", prdy, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_pd", resp_pd, 0);
        chk("rst_wr_en", {d1_wr_en, d0_wr_en}, 0);
        chk("rst_offset", reg_offset, 0);
        chk("rst_wr_data", reg_wr_data, 0);
        chk("rst_op_en", op_en_out, 0);
        rstn = 1'b1;
        tick;

        // read S_POINTER straight after reset
        drive(22'h2401, 32'h0, 1'b0, 1'b0); tick; idle();
        chk("rd_ptr_n1", resp_valid, 0);
        tick;
        chk("rd_ptr_n2_valid", resp_valid, 1);
        chk("rd_ptr_n2_pd", resp_pd, 34'h0);
        tick;
        chk("rd_ptr_n3", resp_valid, 0);

        // producer=1, then forwarded write lands in group 1
        drive(22'h2401, 32'h1, 1'b1, 1'b1); tick;
        chk("ptr_wr_no_fwd", {d1_wr_en, d0_wr_en}, 0);
        drive(22'h2404, 32'h0000_ABCD, 1'b1, 1'b1); tick; idle();
        chk("ptr_wr_resp_valid", resp_valid, 1);
        chk("ptr_wr_resp_pd", resp_pd, 34'h2_0000_0000);
        chk("grp_wr_en", {d1_wr_en, d0_wr_en}, 2'b10);
        chk("grp_wr_offset", reg_offset, 12'h010);
        chk("grp_wr_data", reg_wr_data, 32'h0000_ABCD);
        tick;
        chk("grp_wr_resp_valid", resp_valid, 1);
        chk("grp_wr_resp_pd", resp_pd, 34'h2_0000_0000);
        chk("grp_wr_en_done", {d1_wr_en, d0_wr_en}, 0);

        // group read muxed by producer
        drive(22'h2403, 32'h0, 1'b0, 1'b0); tick; idle(); tick;
        chk("grp_rd_p1", resp_pd, 34'h0_2222_2222);
        drive(22'h2401, 32'h0, 1'b1, 1'b0); tick;
        drive(22'h2403, 32'h0, 1'b0, 1'b0); tick;
        chk("posted_no_resp", resp_valid, 0);
        idle(); tick;
        chk("grp_rd_p0_valid", resp_valid, 1);
        chk("grp_rd_p0", resp_pd, 34'h0_1111_1111);

        // op_en group 0, read back-to-back, then done
        drive(22'h2402, 32'h1, 1'b1, 1'b0); tick;
        drive(22'h2400, 32'h0, 1'b0, 1'b0); tick; idle(); tick;
        chk("status_running", resp_pd, 34'h0_0000_0001);
        chk("op_en_running", op_en_out, 1);
        done = 1'b1; tick; done = 1'b0;
        chk("op_en_after_done", op_en_out, 0);
        drive(22'h2401, 32'h0, 1'b0, 1'b0); tick; idle(); tick;
        chk("ptr_after_done", resp_pd, 34'h0_0001_0000);

        // group 0 enabled while consumer=1 -> pending
        drive(22'h2402, 32'h1, 1'b1, 1'b0); tick;
        drive(22'h2400, 32'h0, 1'b0, 1'b0); tick; idle(); tick;
        chk("status_pending", resp_pd, 34'h0_0000_0002);
        chk("op_en_pending", op_en_out, 0);
        done = 1'b1; tick; done = 1'b0;
        chk("consumer_wrap", op_en_out, 1);

        // write op_en=1 colliding with done clearing the same group
        drive(22'h2402, 32'h0, 1'b1, 1'b0); tick; idle(); tick;
        chk("op_en_cleared", op_en_out, 0);
        drive(22'h2402, 32'h1, 1'b1, 1'b0); tick; idle();
        done = 1'b1; tick; done = 1'b0;
        chk("collide_op_en_out", op_en_out, 0);
        drive(22'h2401, 32'h0, 1'b0, 1'b0); tick;
        drive(22'h2400, 32'h0, 1'b0, 1'b0); tick; idle();
        chk("collide_ptr", resp_pd, 34'h0_0001_0000);
        tick;
        chk("collide_status", resp_pd, 34'h0_0000_0002);

        // out-of-window posted write then read
        drive(22'h0000, 32'h5555, 1'b1, 1'b0); tick;
        drive(22'h0000, 32'h0, 1'b0, 1'b0);
        chk("oow_wr_en", {d1_wr_en, d0_wr_en}, 0);
        tick; idle();
        resp_cnt = 0; pd_cap = '0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) begin
                resp_cnt++;
                pd_cap = resp_pd;
            end
            tick;
        end
        chk("oow_resp_count", resp_cnt, 1);
        chk("oow_resp_pd", pd_cap, 34'h1_0000_0000);

        // out-of-window non-posted write aliasing D_OP_ENABLE has no effect
        drive(22'h2802, 32'h0, 1'b1, 1'b1); tick; idle();
        chk("oow_np_wr_en", {d1_wr_en, d0_wr_en}, 0);
        tick;
        chk("oow_np_resp", resp_pd, 34'h3_0000_0000);
        drive(22'h2400, 32'h0, 1'b0, 1'b0); tick; idle(); tick;
        chk("oow_no_side_effect", resp_pd, 34'h0_0000_0002);

        // reset in the cycle after an accept
        drive(22'h2401, 32'h1, 1'b1, 1'b0); tick;
        drive(22'h2402, 32'h1, 1'b1, 1'b0); tick; idle(); tick;
        chk("pre_rst_op_en", op_en_out, 1);
        drive(22'h2400, 32'h0, 1'b0, 1'b0); tick; idle();
        rstn = 1'b0; #1;
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_op_en", op_en_out, 0);
        chk("mid_rst_offset", reg_offset, 0);
        chk("mid_rst_pd", resp_pd, 0);
        tick;
        chk("mid_rst_valid2", resp_valid, 0);
        rstn = 1'b1; tick;
        chk("post_rst_valid", resp_valid, 0);
        drive(22'h2401, 32'h0, 1'b0, 1'b0); tick; idle();
        chk("post_rst_n1", resp_valid, 0);
        tick;
        chk("post_rst_n2_valid", resp_valid, 1);
        chk("post_rst_ptr", resp_pd, 34'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
